audio_sample_out_fifo: RTL and testbench
========================================

# audio_sample_out_fifo

Avalon-MM slave that buffers multi-channel audio sample frames written by the NIOS II and presents one frame at a time on a parallel output port, advancing on each codec sample strobe. It replaces the single-register audio output PIO between the processor and the codec/DSP chain, and adds a frame FIFO, underflow/overflow detection, flush and an optional low-water interrupt.

## Interface
- `DATA_W`, 24, bits per sample (1..32).
- `CHANNELS`, 2, samples per frame (1..8).
- `DEPTH_LOG2`, 4, FIFO depth = 2^DEPTH_LOG2 frames (1..8).

- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, combinational from `address`, zero wait states.
- `sample_tick`  in  1  one-cycle pop strobe, already synchronous to `clk`.
- `out_port`  out  DATA_W*CHANNELS  current frame; channel 0 in LSBs.
- `irq`  out  1  level interrupt, active high.

## Operation
- Write = `chipselect && !write_n`. Reads have no side effects.
- Addr 0 DATA (W): `writedata[DATA_W-1:0]` goes to staging slot `ch_ptr`. `ch_ptr` increments. On the write to channel CHANNELS-1, the staged frame is pushed and `ch_ptr` returns to 0. Reads return 0.
- Addr 1 STATUS (R):
  - `[8:0]` fill level in frames.
  - bit16 full; bit17 empty.
  - bit18 underflow (sticky); bit19 overflow (sticky).
  - `[26:24]` `ch_ptr`.
  - Writing 1 to bit18 or bit19 clears that flag.
- Addr 2 CONTROL (R/W):
  - bit0 enable.
  - bit1 flush: self-clearing and always reads 0.
  - bit2 irq_en.
  - `[15:8]` low_water.
- Addr 3: reads 0; writes are ignored.
- Pop: when `sample_tick` is high and enable is 1 and the FIFO is non-empty, the head frame loads into `out_port` and the level decrements.
- Tick with enable=1 and FIFO empty: `out_port` holds its value and underflow is set.
- Tick with enable=0: ignored, with no flag change.
- Frame push while full: the frame is dropped, overflow is set, and `ch_ptr` still wraps to 0.
- Push and pop in the same cycle:
  - Full FIFO: both take effect and the level is unchanged; no overflow.
  - Empty FIFO: the pop underflows and the push is accepted (no bypass), so the level becomes 1.
- Flush: level←0, rd/wr pointers←0, `ch_ptr`←0, staging discarded. `out_port` and the sticky flags are unchanged. A DATA push or tick in the same cycle as flush is discarded.
- W1C in the same cycle as a new set event: the set wins.
- Reset values: `out_port`=0, `readdata` reflects reset registers, level=0, empty=1, flags=0, CONTROL=0, `ch_ptr`=0, `irq`=0.

## Timing
- Register and FIFO state update on the `clk` edge that samples the write or tick. STATUS reflects the change on the next cycle.
- `out_port` changes on the edge that samples `sample_tick`, so it is valid 1 cycle after the tick. A tick held high for N cycles performs N pops.
- DATA write to `out_port` latency: at least 1 cycle after the frame-completing write, plus wait for the next tick.
- `irq` is combinational from registered state, so it follows a level change by 1 cycle.
- Reset is asynchronous: assertion mid-frame discards staging and FIFO contents immediately.

## Configuration
- `AUDIO_OUT_FIFO_IRQ_EN` defined:
  - `irq` = irq_en && (level <= low_water || underflow).
  - CONTROL bit2 and `[15:8]` are writable.
- `AUDIO_OUT_FIFO_IRQ_EN` undefined:
  - `irq` is tied 0.
  - CONTROL bit2 and `[15:8]` read 0 and ignore writes; no threshold logic is synthesised.

## Test plan
- Reset, then read STATUS → 0x0002_0000 (empty); `out_port`=0; `irq`=0.
- CHANNELS=2: write DATA 0x000111, 0x000222; set enable; pulse tick → 1 cycle later `out_port`=0x000222_000111, level 1→0.
- Fill 16 frames, write a 17th → full=1, overflow=1, level=16, 17th frame never appears on `out_port`. Write STATUS 0x80000 → overflow=0.
- Empty FIFO, enable=1, tick → underflow=1 and `out_port` unchanged. With the macro defined and irq_en=1, `irq`=1. Same-cycle frame push plus tick → level=1, underflow=1.
- Write one sample, then CONTROL flush → `ch_ptr`=0, level=0. The next two DATA writes form a clean frame.
- Macro defined, low_water=3, irq_en=1: drain from level 5 → `irq` rises 1 cycle after level reaches 3. Macro undefined: CONTROL readback of 0x0304 → 0x0000, `irq` stays 0.

Source files
------------

// File: rtl/audio_sample_out_fifo_if.sv
// Avalon-MM slave bus between the NIOS II and the audio sample output FIFO.
// readdata is driven combinationally by the slave from the current address.
interface audio_sample_out_fifo_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/audio_sample_out_fifo.sv
// Frame FIFO between the CPU and the codec: samples are staged per channel, pushed as
// whole frames and popped onto out_port on sample_tick. Macro AUDIO_OUT_FIFO_IRQ_EN adds the low-water irq.
module audio_sample_out_fifo #(
  parameter int DATA_W     = 24,
  parameter int CHANNELS   = 2,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  audio_sample_out_fifo_if.slave       bus,
  input  logic                         sample_tick,
  output logic [DATA_W*CHANNELS-1:0]   out_port,
  output logic                         irq
);
  localparam int FRAME_W = DATA_W * CHANNELS;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LVL_W   = DEPTH_LOG2 + 1;
  localparam int STG     = (CHANNELS > 1) ? CHANNELS - 1 : 1;
  localparam logic [2:0] LAST_CH = 3'(CHANNELS - 1);

  logic [FRAME_W-1:0]    fifo_mem [DEPTH];
  logic [DATA_W-1:0]     stage_q  [STG];
  logic [DATA_W-1:0]     stage_d  [STG];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [2:0]            ch_ptr_q, ch_ptr_d;
  logic [FRAME_W-1:0]    out_port_q, out_port_d;
  logic                  underflow_q, underflow_d, overflow_q, overflow_d;
  logic                  enable_q, enable_d;
  logic [FRAME_W-1:0]    push_frame;

  logic wr_en, data_wr, stat_wr, ctrl_wr, flush;
  logic full, empty, tick_act, pop, push_req, push_ok, stage_wr;

  assign wr_en    = bus.chipselect && !bus.write_n;
  assign data_wr  = wr_en && (bus.address == 2'd0);
  assign stat_wr  = wr_en && (bus.address == 2'd1);
  assign ctrl_wr  = wr_en && (bus.address == 2'd2);
  assign flush    = ctrl_wr && bus.writedata[1];

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  // A flush in the same cycle swallows the tick entirely, including the underflow check.
  assign tick_act = sample_tick && enable_q && !flush;
  assign pop      = tick_act && !empty;
  assign push_req = data_wr && (ch_ptr_q == LAST_CH);
  assign push_ok  = push_req && (!full || pop);
  assign stage_wr = data_wr && !push_req;

  // The frame-completing sample goes straight into the top slot; earlier ones come from staging.
  generate
    for (genvar gi = 0; gi < CHANNELS - 1; gi++) begin : g_frame
      assign push_frame[gi*DATA_W +: DATA_W] = stage_q[gi];
    end
    for (genvar gi = 0; gi < STG; gi++) begin : g_stage
      assign stage_d[gi] = (stage_wr && ch_ptr_q == 3'(gi)) ? bus.writedata[DATA_W-1:0] : stage_q[gi];
    end
  endgenerate
  assign push_frame[FRAME_W-1 -: DATA_W] = bus.writedata[DATA_W-1:0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    ch_ptr_d    = ch_ptr_q;
    out_port_d  = out_port_q;
    enable_d    = enable_q;
    underflow_d = underflow_q && !(stat_wr && bus.writedata[18]);
    overflow_d  = overflow_q  && !(stat_wr && bus.writedata[19]);

    if (tick_act && empty)      underflow_d = 1'b1;
    if (push_req && !push_ok)   overflow_d  = 1'b1;
    if (ctrl_wr)                enable_d    = bus.writedata[0];

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ch_ptr_d = '0;
    end else begin
      if (pop) begin
        out_port_d = fifo_mem[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (push_req)     ch_ptr_d = '0;
      else if (data_wr) ch_ptr_d = ch_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) fifo_mem[wr_ptr_q] <= push_frame;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ch_ptr_q    <= '0;
      out_port_q  <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      enable_q    <= 1'b0;
      for (int i = 0; i < STG; i++) stage_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ch_ptr_q    <= ch_ptr_d;
      out_port_q  <= out_port_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      enable_q    <= enable_d;
      for (int i = 0; i < STG; i++) stage_q[i] <= stage_d[i];
    end
  end

`ifdef AUDIO_OUT_FIFO_IRQ_EN
  logic       irq_en_q, irq_en_d;
  logic [7:0] low_water_q, low_water_d;

  always_comb begin
    irq_en_d    = irq_en_q;
    low_water_d = low_water_q;
    if (ctrl_wr) begin
      irq_en_d    = bus.writedata[2];
      low_water_d = bus.writedata[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q    <= 1'b0;
      low_water_q <= '0;
    end else begin
      irq_en_q    <= irq_en_d;
      low_water_q <= low_water_d;
    end
  end

  assign irq = irq_en_q && ((9'(level_q) <= {1'b0, low_water_q}) || underflow_q);
  wire [31:0] ctrl_rd = {16'd0, low_water_q, 5'd0, irq_en_q, 1'b0, enable_q};
`else
  assign irq = 1'b0;
  wire [31:0] ctrl_rd = {31'd0, enable_q};
`endif

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd1:    bus.readdata = {5'd0, ch_ptr_q, 4'd0, overflow_q, underflow_q, empty, full,
                               7'd0, 9'(level_q)};
      2'd2:    bus.readdata = ctrl_rd;
      default: bus.readdata = '0;
    endcase
  end

  assign out_port = out_port_q;
endmodule

// File: tb/tb_audio_sample_out_fifo.sv
// Directed plus randomized bench for audio_sample_out_fifo against a queue-based frame model.
// Follows AUDIO_OUT_FIFO_IRQ_EN the same way the design does.
module tb_audio_sample_out_fifo;
  localparam int DW = 24;
  localparam int CH = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sample_tick = 1'b0;
  logic [DW*CH-1:0] out_port;
  logic irq;

  audio_sample_out_fifo_if bus ();

  audio_sample_out_fifo #(.DATA_W(DW), .CHANNELS(CH), .DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .sample_tick (sample_tick),
    .out_port    (out_port),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW*CH-1:0] mq[$];
  logic [DW*CH-1:0] m_out;
  logic [DW-1:0]    m_stage;
  bit   m_unf, m_ovf, m_en, m_ie;
  logic [7:0] m_lw;
  int   m_ch;

  task automatic m_reset();
    mq.delete();
    m_out = '0; m_stage = '0; m_unf = 0; m_ovf = 0; m_en = 0; m_ie = 0; m_lw = '0; m_ch = 0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[8:0]   = 9'(mq.size());
    s[16]    = (mq.size() == DEPTH);
    s[17]    = (mq.size() == 0);
    s[18]    = m_unf;
    s[19]    = m_ovf;
    s[26:24] = 3'(m_ch);
    return s;
  endfunction

  function automatic logic [31:0] exp_ctrl();
`ifdef AUDIO_OUT_FIFO_IRQ_EN
    return {16'd0, m_lw, 5'd0, m_ie, 1'b0, m_en};
`else
    return {31'd0, m_en};
`endif
  endfunction

  function automatic logic exp_irq();
`ifdef AUDIO_OUT_FIFO_IRQ_EN
    return m_ie && ((mq.size() <= int'(m_lw)) || m_unf);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle; peeks STATUS and CONTROL through the read mux.
  task automatic check_all(input string tag);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.address = 2'd1;
    #1 chk({tag, ".status"}, 64'(bus.readdata), 64'(exp_status()));
    bus.address = 2'd2;
    #1 chk({tag, ".control"}, 64'(bus.readdata), 64'(exp_ctrl()));
    bus.address = 2'd3;
    #1 chk({tag, ".addr3"}, 64'(bus.readdata), 64'd0);
    chk({tag, ".out_port"}, 64'(out_port), 64'(m_out));
    chk({tag, ".irq"}, 64'(irq), 64'(exp_irq()));
  endtask

  task automatic model_apply(input bit wr, input bit [1:0] a, input bit [31:0] d, input bit tk);
    bit flush;
    int pre;
    bit popped;
    flush = wr && a == 2'd2 && d[1];
    pre = mq.size();
    popped = 0;
    if (wr && a == 2'd1) begin
      if (d[18]) m_unf = 0;
      if (d[19]) m_ovf = 0;
    end
    if (tk && m_en && !flush) begin
      if (pre > 0) begin m_out = mq.pop_front(); popped = 1; end
      else m_unf = 1;
    end
    if (wr && a == 2'd0) begin
      if (m_ch == CH - 1) begin
        if (pre == DEPTH && !popped) m_ovf = 1;
        else mq.push_back({d[DW-1:0], m_stage});
        m_ch = 0;
      end else begin
        m_stage = d[DW-1:0];
        m_ch++;
      end
    end
    if (wr && a == 2'd2) begin
      m_en = d[0];
`ifdef AUDIO_OUT_FIFO_IRQ_EN
      m_ie = d[2];
      m_lw = d[15:8];
`endif
      if (flush) begin mq.delete(); m_ch = 0; end
    end
  endtask

  task automatic cycle(input bit wr, input bit [1:0] a, input bit [31:0] d, input bit tk);
    bus.chipselect = wr;
    bus.write_n = !wr;
    bus.address = a;
    bus.writedata = d;
    sample_tick = tk;
    @(posedge clk);
    model_apply(wr, a, d, tk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    sample_tick = 1'b0;
  endtask

  task automatic wr_frame(input logic [31:0] s0, input logic [31:0] s1);
    cycle(1, 2'd0, s0, 0);
    cycle(1, 2'd0, s1, 0);
  endtask

  initial begin
    bit [31:0] d;
    bit [1:0] a;
    bit wr, tk;
    bus.address = '0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = '0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check_all("reset");
    bus.address = 2'd1;
    #1 chk("reset.status_const", 64'(bus.readdata), 64'h0002_0000);
    chk("reset.out_port_zero", 64'(out_port), 64'd0);

    // Basic frame and pop
    wr_frame(32'h000111, 32'h000222);
    cycle(1, 2'd2, 32'h1, 0);
    check_all("basic.pre_tick");
    cycle(0, 2'd0, 0, 1);
    chk("basic.frame", 64'(out_port), 64'h000222_000111);
    check_all("basic.post_tick");

    // Fill to full, then an extra frame that must be dropped
    for (int i = 0; i < DEPTH; i++) wr_frame($urandom, $urandom);
    check_all("fill.full");
    wr_frame(32'hABCDEF, 32'h123456);
    check_all("fill.overflow");
    cycle(1, 2'd1, 32'h0008_0000, 0);
    check_all("fill.w1c_ovf");
    // Same-cycle push and pop while full: level stays, no overflow
    cycle(1, 2'd0, $urandom, 0);
    cycle(1, 2'd0, $urandom, 1);
    check_all("full.push_pop");
    while (mq.size() > 0) begin
      cycle(0, 2'd0, 0, 1);
      check_all("drain");
    end

    // Underflow on empty, irq enabled
    cycle(1, 2'd2, 32'h5, 0);
    cycle(0, 2'd0, 0, 1);
    check_all("underflow.empty_tick");
    cycle(1, 2'd1, 32'h0004_0000, 0);
    check_all("underflow.w1c");
    // W1C colliding with a new underflow: set wins
    cycle(1, 2'd1, 32'h0004_0000, 1);
    check_all("underflow.set_wins");
    // Same-cycle push plus tick on empty FIFO
    cycle(1, 2'd0, 32'h0AAAAA, 0);
    cycle(1, 2'd0, 32'h0BBBBB, 1);
    check_all("empty.push_tick");
    cycle(0, 2'd0, 0, 1);
    check_all("empty.push_tick_pop");

    // Tick with enable=0 is ignored
    cycle(1, 2'd1, 32'h000C_0000, 0);
    cycle(1, 2'd2, 32'h0, 0);
    cycle(0, 2'd0, 0, 1);
    check_all("disabled.tick");

    // Flush mid-frame, also discarding a same-cycle tick
    wr_frame(32'h111111, 32'h222222);
    cycle(1, 2'd0, 32'h333333, 0);
    check_all("flush.pre");
    cycle(1, 2'd2, 32'h3, 1);
    check_all("flush.post");
    wr_frame(32'h444444, 32'h555555);
    cycle(0, 2'd0, 0, 1);
    check_all("flush.clean_frame");

    // Low-water irq while draining from 5
    cycle(1, 2'd2, 32'h0305, 0);
    check_all("lowwater.ctrl");
    for (int i = 0; i < 5; i++) wr_frame($urandom, $urandom);
    check_all("lowwater.level5");
    for (int i = 0; i < 5; i++) begin
      cycle(0, 2'd0, 0, 1);
      check_all("lowwater.drain");
    end
    cycle(1, 2'd2, 32'h0304, 0);
    check_all("ctrl.readback_0304");

    // Randomized traffic
    cycle(1, 2'd1, 32'h000C_0000, 0);
    for (int i = 0; i < 400; i++) begin
      wr = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      d  = $urandom;
      if (a == 2'd2) begin
        d[0] = ($urandom_range(0, 5) != 0);
        if ($urandom_range(0, 9) != 0) d[1] = 1'b0;
      end
      tk = ($urandom_range(0, 2) == 0);
      cycle(wr, a, d, tk);
      check_all("random");
    end

    // Asynchronous reset mid-frame
    cycle(1, 2'd0, 32'h00F00D, 0);
    #2 reset_n = 1'b0;
    m_reset();
    #1 check_all("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    check_all("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
